// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding and default geometry for the arbiter.
package mem_arbiter_pkg;
  typedef enum logic {SERVE, CLEAR} state_t;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 13;
  localparam int DEPTH_DEF = 64;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; last=1 means requester 1 won most recently.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin access to a single-port memory with a zero-sweep clear.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  input  logic              clr,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_w_rb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_out
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic last;
  logic [1:0] pick;
  logic sweep_end;
  rr_pick2 u_pick (.req({req1, req0}), .last(last), .gnt(pick));
  assign sweep_end = cnt == ADDR_W'(DEPTH - 1);
  always_comb begin
    state_nx = state == SERVE ? (clr ? CLEAR : SERVE) : (sweep_end ? SERVE : CLEAR);
    clr_busy = state == CLEAR;
    gnt0 = ~clr_busy & pick[0];
    gnt1 = ~clr_busy & pick[1];
    mem_w_rb = clr_busy | (gnt0 & we0) | (gnt1 & we1);
    mem_addr = clr_busy ? cnt : gnt1 ? addr1 : addr0;
    mem_data_in = clr_busy ? '0 : gnt1 ? wdata1 : wdata0;
  end
  always_ff @(posedge clk)
    if (reset) state <= SERVE;
    else state <= state_nx;
  // Counter returns to 0 on the last sweep write so it never steps past DEPTH-1.
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      last <= 1'b1;
      clr_done <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      cnt <= (clr_busy & ~sweep_end) ? cnt + 1'b1 : '0;
      clr_done <= clr_busy & sweep_end;
      if (gnt0 | gnt1) last <= gnt1;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0) rdata0 <= mem_out;
      if (gnt1 & ~we1) rdata1 <= mem_out;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a per-cycle behavioural model and literal spot checks.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 13;
  localparam int DEPTH = 64;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, clr_busy, clr_done, mem_w_rb;
  logic [DW-1:0] rdata0, rdata1, mem_data_in, mem_out;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [DEPTH];
  int total = 0, bad = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .clr(clr), .clr_busy(clr_busy),
    .clr_done(clr_done), .mem_w_rb(mem_w_rb), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    return DW'(i * 7 + 1);
  endfunction

  // Memory reloads a known pattern whenever reset is held.
  assign mem_out = mem[mem_addr];
  always @(posedge clk)
    if (reset) for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    else if (mem_w_rb) mem[mem_addr] <= mem_data_in;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit started = 1'b0;
  int sweep_left = 0, sweep_idx = 0;
  bit m_last = 1'b1, m_rv0 = 1'b0, m_rv1 = 1'b0, m_done = 1'b0;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit e_g0 = 1'b0, e_g1 = 1'b0, e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;

  always @(negedge clk)
    if (started) begin
      e_g0 = sweep_left == 0 && req0 && (!req1 || m_last);
      e_g1 = sweep_left == 0 && req1 && !e_g0;
      e_we = sweep_left > 0 ? 1'b1 : e_g0 ? we0 : e_g1 ? we1 : 1'b0;
      e_addr = sweep_left > 0 ? AW'(sweep_idx) : e_g1 ? addr1 : addr0;
      e_data = sweep_left > 0 ? '0 : e_g1 ? wdata1 : wdata0;
      chk("gnt0", gnt0, e_g0);
      chk("gnt1", gnt1, e_g1);
      chk("mem_w_rb", mem_w_rb, e_we);
      if (e_g0 || e_g1 || sweep_left > 0) chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_data_in", mem_data_in, e_data);
      chk("clr_busy", clr_busy, sweep_left > 0);
      chk("clr_done", clr_done, m_done);
      chk("rvalid0", rvalid0, m_rv0);
      chk("rvalid1", rvalid1, m_rv1);
      chk("rdata0", rdata0, m_rd0);
      chk("rdata1", rdata1, m_rd1);
    end

  always @(posedge clk)
    if (reset) begin
      started <= 1'b1;
      sweep_left <= 0;
      sweep_idx <= 0;
      m_last <= 1'b1;
      m_rv0 <= 1'b0;
      m_rv1 <= 1'b0;
      m_rd0 <= '0;
      m_rd1 <= '0;
      m_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= init_val(i);
    end else if (started) begin
      m_done <= sweep_left == 1;
      sweep_left <= sweep_left > 0 ? sweep_left - 1 : clr ? DEPTH : 0;
      sweep_idx <= sweep_left > 0 ? sweep_idx + 1 : 0;
      m_last <= e_g1 ? 1'b1 : e_g0 ? 1'b0 : m_last;
      m_rv0 <= e_g0 && !e_we;
      m_rv1 <= e_g1 && !e_we;
      if (e_g0 && !e_we) m_rd0 <= ref_mem[e_addr];
      if (e_g1 && !e_we) m_rd1 <= ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] <= e_data;
    end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n, dn;
    step();
    step();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'd5; addr1 = 6'd9;
    #1;
    chk("contend_c0_gnt0", gnt0, 1);
    chk("contend_c0_gnt1", gnt1, 0);
    step();
    req0 = 1'b0;
    #1;
    chk("contend_c1_gnt1", gnt1, 1);
    chk("contend_c1_rvalid0", rvalid0, 1);
    chk("contend_c1_rdata0", rdata0, 13'd36);
    step();
    req1 = 1'b0;
    #1;
    chk("contend_c2_rvalid1", rvalid1, 1);
    chk("contend_c2_rdata1", rdata1, 13'd64);
    chk("contend_c2_rvalid0", rvalid0, 0);

    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd3; wdata0 = 13'h1ABC;
    #1;
    chk("wr_gnt0", gnt0, 1);
    chk("wr_mem_w_rb", mem_w_rb, 1);
    step();
    req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; addr1 = 6'd3;
    #1;
    chk("raw_gnt1", gnt1, 1);
    step();
    req1 = 1'b0;
    #1;
    chk("raw_rvalid1", rvalid1, 1);
    chk("raw_rdata1", rdata1, 13'h1ABC);

    req0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req1 = k >= 2 && k <= 5;
      addr0 = AW'(k); addr1 = AW'(k + 40);
      #1;
      if (k == 3) chk("alt_wait_gnt0", gnt0, 1);
      if (k == 4) chk("alt_gnt1", gnt1, 1);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;

    clr = 1'b1;
    #1;
    chk("clr_same_cycle_busy", clr_busy, 0);
    step();
    clr = 1'b0; req0 = 1'b1; addr0 = 6'd31;
    #1;
    n = 0; dn = 0;
    while (clr_busy && n < 100) begin
      chk("sweep_gnt0_low", gnt0, 0);
      dn += int'(clr_done);
      n++;
      step();
    end
    chk("sweep_len", n, 64);
    chk("sweep_done_pulse", clr_done, 1);
    chk("sweep_no_early_done", dn, 0);
    chk("post_sweep_gnt0", gnt0, 1);
    step();
    addr0 = 6'd0;
    #1;
    chk("read31_zero", rdata0, 0);
    chk("done_single", clr_done, 0);
    step();
    addr0 = 6'd63;
    #1;
    chk("read0_zero", rdata0, 0);
    step();
    req0 = 1'b0;
    #1;
    chk("read63_zero", rdata0, 0);

    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0; dn = 0;
    while (clr_busy && n < 100) begin
      clr = n == 10;
      dn += int'(clr_done);
      n++;
      step();
    end
    clr = 1'b0;
    dn += int'(clr_done);
    step();
    dn += int'(clr_done);
    chk("repulse_len", n, 64);
    chk("repulse_done_count", dn, 1);

    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0;
    while (clr_busy && n < 20) begin
      n++;
      step();
    end
    chk("abort_reached_20", n, 20);
    reset = 1'b1; req1 = 1'b1; addr1 = 6'd4;
    step();
    reset = 1'b0;
    #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_no_done", clr_done, 0);
    chk("abort_gnt1", gnt1, 1);
    step();
    req1 = 1'b0;
    #1;
    chk("abort_rvalid1", rvalid1, 1);
    chk("abort_rdata1", rdata1, 13'd29);
    chk("abort_still_no_done", clr_done, 0);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 13, memory word width.
REQ-003 The block SHALL have parameter DEPTH, default 64, number of words swept by a clear.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req0 / req1  input  1  requester N has a pending access.
REQ-008 we0 / we1  input  1  requester N access is a write (1) or read (0).
REQ-009 addr0 / addr1  input  ADDR_W  requester N address.
REQ-010 wdata0 / wdata1  input  DATA_W  requester N write data.
REQ-011 gnt0 / gnt1  output  1  requester N access is accepted this cycle.
REQ-012 rdata0 / rdata1  output  DATA_W  registered read data for requester N.
REQ-013 rvalid0 / rvalid1  output  1  rdataN is valid this cycle.
REQ-014 clr  input  1  request a full-memory zero sweep.
REQ-015 clr_busy  output  1  sweep in progress.
REQ-016 clr_done  output  1  one-cycle pulse after the last sweep write.
REQ-017 mem_w_rb  output  1  memory write enable.
REQ-018 mem_addr  output  ADDR_W  memory address.
REQ-019 mem_data_in  output  DATA_W  memory write data.
REQ-020 mem_out  input  DATA_W  memory combinational read data at mem_addr.

Function
REQ-021 The FSM SHALL have two states: SERVE and CLEAR.
REQ-022 In SERVE, gntN SHALL be combinational from reqN and the priority pointer; at most one gnt SHALL be high per cycle.
REQ-023 With only one req high, that requester SHALL be granted in the same cycle.
REQ-024 With both req high, the requester not granted most recently SHALL be granted; the pointer SHALL update on every grant.
REQ-025 During a grant, mem_addr, mem_w_rb (= weN) and mem_data_in SHALL be driven combinationally from the granted requester; with no grant, mem_w_rb SHALL be 0.
REQ-026 The write SHALL commit at the rising edge ending the grant cycle.
REQ-027 For a granted read, mem_out SHALL be captured into rdataN at that edge, and rvalidN SHALL be high for exactly the following cycle.
REQ-028 Requesters SHALL hold req, we, addr and wdata stable until gnt is seen high.
REQ-029 A read of an address in the cycle after a write to it SHALL return the new data.
REQ-030 clr high in SERVE SHALL NOT affect that cycle's grant; the FSM SHALL enter CLEAR on the next cycle with the sweep counter at 0.
REQ-031 In CLEAR, gnt0 and gnt1 SHALL be 0, mem_w_rb SHALL be 1, mem_addr SHALL equal the counter and mem_data_in SHALL be 0; the counter SHALL increment each cycle.
REQ-032 CLEAR SHALL last exactly DEPTH cycles (addresses 0..DEPTH-1); the FSM SHALL then return to SERVE, with clr_done high for the first SERVE cycle.
REQ-033 clr_busy SHALL be high exactly while the state is CLEAR.
REQ-034 clr asserted during CLEAR SHALL be ignored and SHALL NOT restart or extend the sweep.
REQ-035 A sweep counter increment past DEPTH-1 SHALL NOT occur; the counter SHALL be ADDR_W wide.

Reset
REQ-036 On reset, the state SHALL become SERVE, the counter 0 and the pointer set so that req0 wins the first contention.
REQ-037 On reset, rdata0/1 SHALL be 0, rvalid0/1 SHALL be 0 and clr_done SHALL be 0.
REQ-038 Reset asserted mid-sweep SHALL abort the sweep immediately with no clr_done pulse; reset SHALL take priority over clr and req.

Structure
REQ-039 The state encoding SHALL be defined in a shared package; ADDR_W, DATA_W and DEPTH defaults SHALL come from that package.
REQ-040 The two-way round-robin pick SHALL be a sub-module, rr_pick2, with inputs req[1:0] and last, and output gnt[1:0].

Verification
REQ-041 After reset, req0=req1=1 with reads at addr 5 and 9 -> gnt0 in cycle 0 and gnt1 in cycle 1; rvalid0 in cycle 1, then rvalid1 in cycle 2.
REQ-042 req0 writes 13'h1ABC to addr 3, then req1 reads addr 3 -> rdata1=13'h1ABC with rvalid1 one cycle after gnt1.
REQ-043 clr pulse with memory preloaded -> clr_busy high for 64 cycles, gnt low throughout, clr_done pulses once, and subsequent reads of addr 0, 31 and 63 return 0.
REQ-044 clr re-pulsed at sweep cycle 10 -> sweep still ends after 64 total cycles with a single clr_done.
REQ-045 reset asserted at sweep cycle 20 -> next cycle is SERVE, clr_busy=0, no clr_done, and req1 alone is granted immediately.
REQ-046 req0 held high continuously with req1 pulsed -> grants alternate; req1 waits at most 1 cycle.
